// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int NUM_PATTERNS = 4;

    // Expected truth tables, bit index = {a,b}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle down-counter: load a count, decrement while enabled, expire at zero.
module gate_bist_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks {a,b} through 00..11, samples the gate, scores the truth table.
// Optional macro GATE_BIST_LOOP_EN adds loop_mode for back-to-back repeated runs.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT_TT     = TT_AND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef GATE_BIST_LOOP_EN
    input  logic       loop_mode,
`endif
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count,
    output state_t     dbg_state
);

    // start is taken only in IDLE; busy covers SETTLE..FINISH; done is the FINISH cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    // On a loop restart the FINISH cycle already holds pattern 00, so one settle cycle is spent.
    localparam logic [3:0] LOOP_LOAD   = (SETTLE_CYCLES > 1) ? 4'(SETTLE_CYCLES - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] dut_ab_q, dut_ab_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [2:0] err_count_q, err_count_d;
    logic       pass_q, pass_d;

    logic       loop_req;
    logic       mismatch;
    logic       last_pat;
    logic       timer_load;
    logic       timer_en;
    logic [3:0] timer_val;
    logic       timer_expire;

`ifdef GATE_BIST_LOOP_EN
    assign loop_req = loop_mode;
`else
    assign loop_req = 1'b0;
`endif

    assign mismatch = (dut_y != EXPECT_TT[idx_q]);
    assign last_pat = (idx_q == 2'(NUM_PATTERNS - 1));

    gate_bist_timer #(.W(4)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            dut_ab_q    <= 2'd0;
            fail_vec_q  <= 4'd0;
            err_count_q <= 3'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dut_ab_q    <= dut_ab_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (timer_expire) state_d = SAMPLE;
            SAMPLE:  state_d = last_pat ? FINISH : SETTLE;
            FINISH: begin
                if (loop_req) state_d = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        dut_ab_d    = dut_ab_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = 2'd0;
                    dut_ab_d    = 2'd0;
                    fail_vec_d  = 4'd0;
                    err_count_d = 3'd0;
                    pass_d      = 1'b0;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_vec_d[idx_q] = 1'b1;
                    err_count_d       = err_count_q + 3'd1;
                end
                if (last_pat) begin
                    pass_d = (fail_vec_d == 4'd0);
                    if (loop_req) dut_ab_d = 2'd0;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    dut_ab_d = idx_q + 2'd1;
                end
            end
            FINISH: begin
                dut_ab_d = 2'd0;
                if (loop_req) begin
                    idx_d       = 2'd0;
                    fail_vec_d  = 4'd0;
                    err_count_d = 3'd0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        timer_load = ((state_q == IDLE) && start)
                   || ((state_q == SAMPLE) && !last_pat)
                   || ((state_q == FINISH) && loop_req);
        timer_val  = (state_q == FINISH) ? LOOP_LOAD : SETTLE_LOAD;
        timer_en   = (state_q == SETTLE);
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
        dut_a      = dut_ab_q[1];
        dut_b      = dut_ab_q[0];
        pass       = pass_q;
        fail_vec   = fail_vec_q;
        err_count  = err_count_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: an AND-expecting and an OR-expecting instance exercise a shared model gate.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam int S   = 2;
    localparam int RUN = 4 * (S + 1);

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
`ifdef GATE_BIST_LOOP_EN
    logic loop_mode = 1'b0;
`endif
    logic [3:0] gate_tt = TT_AND;

    logic       a0, b0, y0, busy0, done0, pass0;
    logic [3:0] fv0;
    logic [2:0] ec0;
    state_t     st0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] fv1;
    logic [2:0] ec1;
    state_t     st1;

    assign y0 = gate_tt[{a0, b0}];
    assign y1 = gate_tt[{a1, b1}];

    gate_bist_ctrl #(.SETTLE_CYCLES(S), .EXPECT_TT(TT_AND)) u_and (
        .clk(clk), .rst(rst), .start(start),
`ifdef GATE_BIST_LOOP_EN
        .loop_mode(loop_mode),
`endif
        .dut_a(a0), .dut_b(b0), .dut_y(y0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_vec(fv0), .err_count(ec0), .dbg_state(st0)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(S), .EXPECT_TT(TT_OR)) u_or (
        .clk(clk), .rst(rst), .start(start),
`ifdef GATE_BIST_LOOP_EN
        .loop_mode(loop_mode),
`endif
        .dut_a(a1), .dut_b(b1), .dut_y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_vec(fv1), .err_count(ec1), .dbg_state(st1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    // scoreboard state
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pat_acc  = -1000;
    int chk_mode = 0;
    bit tmo_evt  = 1'b0;
    bit chk_end  = 1'b0;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return 3'(n);
    endfunction

    // Reference: a pattern fails where the gate's truth table differs from the expected one.
    function automatic logic [31:0] model(input int done_cyc, input logic [3:0] g);
        logic [3:0] f0;
        logic [3:0] f1;
        f0 = g ^ TT_AND;
        f1 = g ^ TT_OR;
        return {16'(done_cyc), (f0 == 4'd0), f0, popcnt4(f0), (f1 == 4'd0), f1, popcnt4(f1)};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        int t;
        logic [31:0] e;
        if (chk_mode == 1) begin
            check("rst_state0", int'(st0), int'(IDLE));
            check("rst_outs0", int'({a0, b0, busy0, done0, pass0, fv0, ec0}), 0);
            check("rst_state1", int'(st1), int'(IDLE));
            check("rst_outs1", int'({a1, b1, busy1, done1, pass1, fv1, ec1}), 0);
        end
        if (chk_mode == 2) begin
            check("idle_state0", int'(st0), int'(IDLE));
            check("idle_busy_done", int'({busy0, done0, busy1, done1}), 0);
        end
        if (!rst) begin
            t = cyc - pat_acc;
            if (t >= 1 && t <= RUN) begin
                check("pattern", int'({a0, b0}), (t - 1) / (S + 1));
                check("busy_in_run", int'(busy0), 1);
            end else if (t == RUN + 2) begin
                check("dut_back_to_00", int'({a0, b0}), 0);
                check("busy_after_run", int'(busy0), 0);
            end
        end
        if (done0 || done1) begin
            if (exp_q.size() == 0) begin
                check("done_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, int'(e[31:16]));
                check("done_and", int'(done0), 1);
                check("done_or", int'(done1), 1);
                check("pass_and", int'(pass0), int'(e[15]));
                check("fail_vec_and", int'(fv0), int'(e[14:11]));
                check("err_count_and", int'(ec0), int'(e[10:8]));
                check("pass_or", int'(pass1), int'(e[7]));
                check("fail_vec_or", int'(fv1), int'(e[6:3]));
                check("err_count_or", int'(ec1), int'(e[2:0]));
            end
        end
        if (tmo_evt) check("idle_timeout_busy", int'(busy0 | busy1), 0);
        if (chk_end) check("queue_empty", exp_q.size(), 0);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] g, input bit track);
        gate_tt = g;
        start   = 1'b1;
        exp_q.push_back(model(cyc + 1 + RUN, g));
        if (track) pat_acc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy0 || busy1) && k < 80) begin
            step();
            k++;
        end
        if (busy0 || busy1) begin
            tmo_evt = 1'b1;
            step();
            tmo_evt = 1'b0;
        end
        step();
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b1;
        step();
        step();
        chk_mode = 1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk_mode = 0;
        step();

        // directed gates: good AND, OR gate, stuck-at-1, XOR
        issue(TT_AND, 1'b1);
        wait_idle();
        issue(TT_OR, 1'b1);
        wait_idle();
        issue(4'b1111, 1'b1);
        wait_idle();
        issue(TT_XOR, 1'b1);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            issue(4'($urandom_range(0, 15)), 1'b1);
            wait_idle();
        end

        // start held high across a whole run: second run accepted right after FINISH
        gate_tt = TT_AND;
        c = cyc;
        start = 1'b1;
        exp_q.push_back(model(c + 1 + RUN, TT_AND));
        exp_q.push_back(model(c + 3 + 2 * RUN, TT_AND));
        repeat (16) step();
        start = 1'b0;
        wait_idle();

        // reset mid-run aborts without a done pulse
        gate_tt = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_mode = 1;
        step();
        chk_mode = 0;
        repeat (20) step();

`ifdef GATE_BIST_LOOP_EN
        gate_tt   = TT_AND;
        c         = cyc;
        loop_mode = 1'b1;
        start     = 1'b1;
        exp_q.push_back(model(c + 13, TT_AND));
        exp_q.push_back(model(c + 25, TT_AND));
        exp_q.push_back(model(c + 37, TT_AND));
        step();
        start = 1'b0;
        repeat (25) step();
        loop_mode = 1'b0;
        repeat (12) step();
        chk_mode = 2;
        step();
        chk_mode = 0;
        wait_idle();
`endif

        chk_end = 1'b1;
        step();
        chk_end = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
